// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// This is the register-access controller that sits behind an SPI slave. Each
// received 16-bit word is decoded as a command of the form {wr, 3'bx, addr, 8'bx}:
//   - A write command takes the next word as data for cfg[addr].
//   - A read command loads spi_din so that the slave shifts out the response
//     two transfers later.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   spi_ss       raw slave select (1 = deselected); synchronized internally
//   spi_done     one-cycle pulse, spi_dout holds a received word
//   spi_dout     received word
//   spi_din      word the slave loads for its next transfer
//   ch_data      four read-only channel values, channel n at [16n+15:16n]
//   cfg          eight configuration registers, register n at [16n+15:16n]
//   cfg_wr_stb   one-cycle pulse when a cfg register is written
//   cfg_wr_addr  index of the written register, valid with cfg_wr_stb
//
// Address map: 0-7 cfg (R/W), 8-11 ch_data (RO),
//              12 {abort_cnt, err_cnt} (RO), 13 ID_VALUE, 14-15 zero.
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hA51C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_ss,
  input  logic                    spi_done,
  input  logic [DATA_WIDTH-1:0]   spi_dout,
  output logic [DATA_WIDTH-1:0]   spi_din,
  input  logic [4*DATA_WIDTH-1:0] ch_data,
  output logic [8*DATA_WIDTH-1:0] cfg,
  output logic                    cfg_wr_stb,
  output logic [2:0]              cfg_wr_addr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_DATA = 2'd1,
    S_RD_OUT  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;

  // r_pend marks the single commit cycle that follows an accepted spi_done.
  // Together with r_state it selects the committed action:
  //   - IDLE:    load the read value.
  //   - WR_DATA: write cfg.
  //   - RD_OUT:  end the read.
  logic                          r_pend;
  logic [3:0]                    r_addr;
  logic [DATA_WIDTH-1:0]         r_wr_data;
  logic [DATA_WIDTH-1:0]         r_din;
  logic [7:0][DATA_WIDTH-1:0]    r_cfg;
  logic                          r_wr_stb;
  logic [2:0]                    r_wr_addr;
  logic [7:0]                    r_err_cnt;
  logic [7:0]                    r_abort_cnt;
  logic                          r_ss_meta;
  logic                          r_ss_sync;
  logic                          r_ss_dly;

  logic                          w_pend_nxt;
  logic [3:0]                    w_addr_nxt;
  logic [DATA_WIDTH-1:0]         w_wr_data_nxt;
  logic [DATA_WIDTH-1:0]         w_din_nxt;
  logic [DATA_WIDTH-1:0]         w_rd_val;
  logic                          w_cfg_we;
  logic                          w_err_inc;
  logic                          w_abort_inc;
  logic                          w_desel;

  // A deselect event is the rising edge of the synchronized slave select.
  assign w_desel = r_ss_sync & ~r_ss_dly;

  // Read mux. ch_data passes through here only in the cycle that loads r_din,
  // so the channel values are captured once per read command.
  always_comb begin
    w_rd_val = '0;
    if (!r_addr[3]) begin
      w_rd_val = r_cfg[r_addr[2:0]];
    end else begin
      case (r_addr[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: w_rd_val = ch_data[{r_addr[1:0], 4'b0000} +: DATA_WIDTH];
        3'd4:                   w_rd_val = {r_abort_cnt, r_err_cnt};
        3'd5:                   w_rd_val = ID_VALUE;
        default:                w_rd_val = '0;
      endcase
    end
  end

  // Next-state and action decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_pend_nxt    = 1'b0;
    w_addr_nxt    = r_addr;
    w_wr_data_nxt = r_wr_data;
    w_din_nxt     = r_din;
    w_cfg_we      = 1'b0;
    w_err_inc     = 1'b0;
    w_abort_inc   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_din_nxt   = w_rd_val;
          w_state_nxt = S_RD_OUT;
        end else if (spi_done) begin
          w_addr_nxt = spi_dout[11:8];
          if (spi_dout[15]) w_state_nxt = S_WR_DATA;
          else              w_pend_nxt  = 1'b1;
        end
      end

      S_WR_DATA: begin
        // spi_done outranks a same-cycle deselect. Once the data word is in,
        // the write always completes.
        if (r_pend) begin
          w_cfg_we    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (spi_done) begin
          if (!r_addr[3]) begin
            w_wr_data_nxt = spi_dout;
            w_pend_nxt    = 1'b1;
          end else begin
            w_err_inc   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_desel) begin
          w_abort_inc = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_RD_OUT: begin
        // The word received here is the dummy transfer and is discarded.
        if (w_desel || r_pend) begin
          w_din_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (spi_done) begin
          w_pend_nxt = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend      <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_din       <= '0;
      // NOTE: the cfg bank is software-visible and must read zero after reset,
      // so it is reset explicitly rather than left as uninitialized storage.
      r_cfg       <= '0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_err_cnt   <= '0;
      r_abort_cnt <= '0;
      r_ss_meta   <= 1'b1;
      r_ss_sync   <= 1'b1;
      r_ss_dly    <= 1'b1;
    end else begin
      r_ss_meta <= spi_ss;
      r_ss_sync <= r_ss_meta;
      r_ss_dly  <= r_ss_sync;

      r_pend    <= w_pend_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_din     <= w_din_nxt;
      r_wr_stb  <= w_cfg_we;

      if (w_cfg_we) begin
        r_cfg[r_addr[2:0]] <= r_wr_data;
        r_wr_addr          <= r_addr[2:0];
      end

      if (w_err_inc && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
      if (w_abort_inc && (r_abort_cnt != 8'hFF))
        r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign spi_din     = r_din;
  assign cfg         = r_cfg;
  assign cfg_wr_stb  = r_wr_stb;
  assign cfg_wr_addr = r_wr_addr;

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SPI word width; only 16 is supported.
REQ-002 Parameter ID_VALUE, default 16'hA51C, constant returned at address 13.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low: a low level sampled on a rising clk edge resets the block.
REQ-005 spi_ss  input  1  raw slave select from the pad; 1 = deselected.
REQ-006 spi_done  input  1  one-cycle pulse from the SPI slave: a word has been received.
REQ-007 spi_dout  input  16  received word; valid in the spi_done cycle.
REQ-008 spi_din  output  16  word the SPI slave loads for transmission.
REQ-009 ch_data  input  64  four 16-bit acquisition channel values; channel n is at bits [16n+15:16n].
REQ-010 cfg  output  128  eight 16-bit configuration registers; register n is at bits [16n+15:16n].
REQ-011 cfg_wr_stb  output  1  one-cycle pulse when a configuration register is written.
REQ-012 cfg_wr_addr  output  3  index of the register written; valid while cfg_wr_stb is high.

Function
REQ-013 Command word format: bit15 = 1 for write, 0 for read; bits[11:8] = address A; bits[14:12] and [7:0] are ignored.
REQ-014 Address map:
- 0-7: cfg registers, read/write.
- 8-11: ch_data channel 0-3, read-only.
- 12: status {abort_cnt[7:0], err_cnt[7:0]}, read-only.
- 13: ID_VALUE, read-only.
- 14-15: read as 16'h0000.
REQ-015 spi_ss SHALL pass through a 2-flop synchronizer; a deselect event is a 0->1 transition of the synchronized signal.
REQ-016 State machine has three states: IDLE, WR_DATA and RD_OUT; reset state is IDLE.
REQ-017 IDLE, spi_done with bit15=1: latch A, go to WR_DATA.
REQ-018 IDLE, spi_done with bit15=0: on the next cycle, load spi_din with the contents of A, then go to RD_OUT.
REQ-019 WR_DATA, spi_done, A<=7: the next cycle writes spi_dout into cfg[A], pulses cfg_wr_stb for one cycle with cfg_wr_addr=A, and returns to IDLE.
REQ-020 WR_DATA, spi_done, A>=8: no register changes, err_cnt increments, return to IDLE.
REQ-021 RD_OUT: spi_din holds the read value until the next spi_done; the cycle after that, spi_din returns to 16'h0000 and the state returns to IDLE.
REQ-022 The word received during RD_OUT is discarded and is not decoded as a command.
REQ-023 Read latency: the response to a command in transfer k is shifted out in transfer k+2; transfer k+1 is a dummy word whose MISO content is undefined.
REQ-024 ch_data SHALL be sampled once, in the cycle after the read-command spi_done; it is not tracked afterwards.
REQ-025 A deselect in WR_DATA aborts the write: no cfg change, abort_cnt increments, state goes to IDLE.
REQ-026 A deselect in RD_OUT clears spi_din to 0 and goes to IDLE; it is not counted as an abort.
REQ-027 A deselect in IDLE has no effect.
REQ-028 If spi_done and a deselect occur in the same cycle, the spi_done is processed first (a write completes), then the state goes to IDLE; abort_cnt does not increment.
REQ-029 err_cnt and abort_cnt are 8-bit saturating counters and hold at 255.
REQ-030 Writing 16'h0000 to address 12 is illegal and counts as an error; status is cleared only by reset.
REQ-031 In IDLE and WR_DATA, spi_din SHALL be 16'h0000.
REQ-032 spi_done is ignored in the cycle that commits a pending action; the SPI slave guarantees at least 16 sck periods between pulses.

Reset
REQ-033 While reset is active: state = IDLE, cfg = 0, spi_din = 16'h0000, cfg_wr_stb = 0, cfg_wr_addr = 0, err_cnt = 0, abort_cnt = 0, synchronizer flops = 1.
REQ-034 Reset asserted mid-transaction SHALL discard any pending write or read with no cfg change.
REQ-035 The first spi_done after reset release is decoded as a command.

Verification
REQ-036 Write: command 16'h8300, then data 16'h1234 -> cfg[3]=16'h1234; cfg_wr_stb high for 1 cycle with cfg_wr_addr=3; other cfg unchanged.
REQ-037 Read: ch_data channel 1 = 16'hBEEF; command 16'h0900, dummy word, word 3 -> spi_din=16'hBEEF during word 2 and is shifted out in word 3; spi_din=0 after word 3 done.
REQ-038 Read-only write: command 16'h8D00, then data 16'hFFFF -> no cfg_wr_stb; status read (16'h0C00) returns 16'h0001.
REQ-039 Abort: command 16'h8500, then spi_ss goes high before the data word -> cfg[5] unchanged; next status read returns 16'h0100.
REQ-040 Same-cycle boundary: data word spi_done and deselect in the same cycle -> write committed, abort_cnt unchanged.
REQ-041 Saturation and reset: 300 read-only writes -> err_cnt=255; rst low for 1 cycle mid-WR_DATA -> all outputs at reset values; the next 16'h0D00 read returns ID_VALUE 16'hA51C.
